fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 48 ++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake, redirect/stall control and
// the decoded instruction presented downstream.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;

  // Fetch unit side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    input  stall,
    output inst_valid,
    output inst,
    output inst_pc,
    output pc_plus4,
    output opcode
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    output stall,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  pc_plus4,
    input  opcode
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction memory,
// presents each returned word downstream with its address, honours stall
// back-pressure and flushes on branch/jump redirects. A redirect that arrives
// while a request is outstanding is parked in pend_pc so the request address
// never changes until the memory acknowledges it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrop} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] inst_word;
  logic [31:0] inst_addr;
  logic        inst_live;
  logic        req;
  logic [31:0] target;

  // Redirect targets are always word aligned.
  assign target = {bus.redirect_pc[31:2], 2'b00};

  // Fetch state machine; redirect outranks both stall and ack capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      pc        <= RESET_PC;
      pend_pc   <= 32'h0;
      inst_word <= 32'h0;
      inst_addr <= 32'h0;
      inst_live <= 1'b0;
      req       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          // Any ack seen here belongs to a request aborted by reset.
          if (bus.redirect) begin
            pc <= target;
          end
          state <= StFetch;
          req   <= 1'b1;
        end

        StFetch: begin
          if (bus.redirect) begin
            inst_live <= 1'b0;
            if (bus.imem_ack) begin
              pc <= target;
            end else begin
              // Keep imem_addr stable; retire the request in StDrop.
              pend_pc <= target;
              state   <= StDrop;
            end
          end else if (bus.imem_ack) begin
            inst_word <= bus.imem_rdata;
            inst_addr <= pc;
            inst_live <= 1'b1;
            pc        <= pc + 32'd4;
            if (bus.stall) begin
              state <= StHold;
              req   <= 1'b0;
            end
          end else begin
            // A stalled live instruction stays; a consumed one retires.
            inst_live <= inst_live & bus.stall;
          end
        end

        StHold: begin
          if (bus.redirect) begin
            inst_live <= 1'b0;
            pc        <= target;
            state     <= StFetch;
            req       <= 1'b1;
          end else if (!bus.stall) begin
            inst_live <= 1'b0;
            state     <= StFetch;
            req       <= 1'b1;
          end
        end

        StDrop: begin
          if (bus.redirect) begin
            inst_live <= 1'b0;
          end
          if (bus.imem_ack) begin
            // Returned word is stale; resume at the most recent target.
            pc    <= bus.redirect ? target : pend_pc;
            state <= StFetch;
          end else if (bus.redirect) begin
            pend_pc <= target;
          end
        end

        default: begin
          state <= StIdle;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = inst_live;
  assign bus.inst       = inst_word;
  assign bus.inst_pc    = inst_addr;
  assign bus.pc_plus4   = inst_addr + 32'd4;
  assign bus.opcode     = inst_word[31:26];

`ifndef SYNTHESIS
  // An outstanding request keeps its address until acknowledged.
  property p_addr_stable;
    @(posedge clk) disable iff (reset)
      (bus.imem_req && !bus.imem_ack) |=> (bus.imem_req && $stable(bus.imem_addr));
  endproperty
  a_addr_stable: assert property (p_addr_stable);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. Each record gives the inputs
// for one clock cycle and the outputs expected just after that rising edge.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          do_reset;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [31:0] e_pc4;
    logic [5:0]  e_op;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(bit rst, logic ack, logic [31:0] rdata, logic redir,
                              logic [31:0] rpc, logic stall, logic e_req,
                              logic [31:0] e_addr, logic e_valid, logic [31:0] e_inst,
                              logic [31:0] e_ipc, logic [31:0] e_pc4, logic [5:0] e_op);
    vec_t v;
    v.do_reset = rst;   v.ack = ack;       v.rdata = rdata;
    v.redir    = redir; v.rpc = rpc;       v.stall = stall;
    v.e_req    = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_inst   = e_inst; v.e_ipc = e_ipc;  v.e_pc4 = e_pc4;
    v.e_op     = e_op;
    return v;
  endfunction

  task automatic check(input string name, input logic [135:0] exp);
    logic [135:0] got;
    got = {bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc,
           bus.pc_plus4, bus.opcode};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {req,addr,valid,inst,inst_pc,pc4,op}=%h expected %h",
               name, got, exp);
    end
  endtask

  // Reset is asserted mid-cycle so its asynchronous effect is observed at once.
  task automatic pulse_reset(input int idx);
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    reset = 1'b1;
    #1;
    check($sformatf("reset_async@%0d", idx), {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 6'h0});
    @(posedge clk);
    #1;
    check($sformatf("reset_held@%0d", idx), {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 6'h0});
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall       = 1'b0;

    // Back-to-back fetch, rdata = addr ^ A5A5_0000.
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 1, 32'h0,  0, 32'h0,        32'h0, 32'h4,  6'h00));
    vecs.push_back(mk(0, 1, 32'hA5A50000, 0, 0, 0, 1, 32'h4,  1, 32'hA5A50000, 32'h0, 32'h4,  6'h29));
    vecs.push_back(mk(0, 1, 32'hA5A50004, 0, 0, 0, 1, 32'h8,  1, 32'hA5A50004, 32'h4, 32'h8,  6'h29));
    vecs.push_back(mk(0, 1, 32'hA5A50008, 0, 0, 0, 1, 32'hC,  1, 32'hA5A50008, 32'h8, 32'hC,  6'h29));
    vecs.push_back(mk(0, 1, 32'hA5A5000C, 0, 0, 0, 1, 32'h10, 1, 32'hA5A5000C, 32'hC, 32'h10, 6'h29));
    // Reset mid-request, then stall on the word at pc 8 (HOLD ignores acks).
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 1, 32'h0,  0, 32'h0,        32'h0, 32'h4,  6'h00));
    vecs.push_back(mk(0, 1, 32'h0C000000, 0, 0, 0, 1, 32'h4,  1, 32'h0C000000, 32'h0, 32'h4,  6'h03));
    vecs.push_back(mk(0, 1, 32'h10000004, 0, 0, 0, 1, 32'h8,  1, 32'h10000004, 32'h4, 32'h8,  6'h04));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h8,  0, 32'h10000004, 32'h4, 32'h8,  6'h04));
    vecs.push_back(mk(0, 1, 32'h14000008, 0, 0, 1, 0, 32'hC,  1, 32'h14000008, 32'h8, 32'hC,  6'h05));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 0, 32'hC,  1, 32'h14000008, 32'h8, 32'hC,  6'h05));
    vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'hC,  1, 32'h14000008, 32'h8, 32'hC,  6'h05));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 0, 32'hC,  1, 32'h14000008, 32'h8, 32'hC,  6'h05));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'hC,  0, 32'h14000008, 32'h8, 32'hC,  6'h05));
    vecs.push_back(mk(0, 1, 32'h1800000C, 0, 0, 0, 1, 32'h10, 1, 32'h1800000C, 32'hC, 32'h10, 6'h06));
    // Redirect to 0x40 while pc 16 is outstanding: address holds, data dropped.
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h40, 0, 1, 32'h10, 0, 32'h1800000C, 32'hC, 32'h10, 6'h06));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,      0, 1, 32'h10, 0, 32'h1800000C, 32'hC, 32'h10, 6'h06));
    vecs.push_back(mk(0, 1, 32'hFC000010, 0, 0,      0, 1, 32'h40, 0, 32'h1800000C, 32'hC, 32'h10, 6'h06));
    vecs.push_back(mk(0, 1, 32'h20000040, 0, 0,      0, 1, 32'h44, 1, 32'h20000040, 32'h40, 32'h44, 6'h08));
    // Redirect with ack in the same cycle; low target bits ignored.
    vecs.push_back(mk(0, 1, 32'h24000044, 1, 32'h103, 0, 1, 32'h100, 0, 32'h20000040, 32'h40, 32'h44, 6'h08));
    vecs.push_back(mk(0, 1, 32'h28000100, 0, 0,       0, 1, 32'h104, 1, 32'h28000100, 32'h100, 32'h104, 6'h0A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,       0, 1, 32'h104, 0, 32'h28000100, 32'h100, 32'h104, 6'h0A));
    // Redirect out of HOLD despite stall, then wrap at the top of memory.
    vecs.push_back(mk(0, 1, 32'h2C000104, 0, 0,            1, 0, 32'h108,      1, 32'h2C000104, 32'h104, 32'h108, 6'h0B));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, 0, 32'h2C000104, 32'h104, 32'h108, 6'h0B));
    vecs.push_back(mk(0, 1, 32'h30000000, 0, 0,            0, 1, 32'h0, 1, 32'h30000000, 32'hFFFFFFFC, 32'h0, 6'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,            1, 1, 32'h0, 1, 32'h30000000, 32'hFFFFFFFC, 32'h0, 6'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,            0, 1, 32'h0, 0, 32'h30000000, 32'hFFFFFFFC, 32'h0, 6'h0C));
    // Two redirects while a request is outstanding: the later one wins.
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h200, 0, 1, 32'h0,   0, 32'h30000000, 32'hFFFFFFFC, 32'h0, 6'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h300, 0, 1, 32'h0,   0, 32'h30000000, 32'hFFFFFFFC, 32'h0, 6'h0C));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0,       0, 1, 32'h300, 0, 32'h30000000, 32'hFFFFFFFC, 32'h0, 6'h0C));
    vecs.push_back(mk(0, 1, 32'h34000300, 0, 0,       1, 0, 32'h304, 1, 32'h34000300, 32'h300, 32'h304, 6'h0D));
    // Reset from HOLD with a live instruction; a late ack in IDLE is ignored.
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0, 0, 32'h0,        32'h0, 32'h4, 6'h00));
    vecs.push_back(mk(0, 1, 32'h38000000, 0, 0, 0, 1, 32'h4, 1, 32'h38000000, 32'h0, 32'h4, 6'h0E));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) begin
        pulse_reset(i);
      end
      bus.imem_ack    = vecs[i].ack;
      bus.imem_rdata  = vecs[i].rdata;
      bus.redirect    = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      bus.stall       = vecs[i].stall;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_inst,
             vecs[i].e_ipc, vecs[i].e_pc4, vecs[i].e_op});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
